// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with direct and
// round-robin scan modes for display row/digit multiplexing.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - async active-low reset
//   en    - enable; when low y is inactive and scan state freezes
//   mode  - 0 = decode sel, 1 = auto scan
//   sel   - direct-mode select [SEL_W]
//   y     - registered one-hot (one-cold if OUT_ACTIVE_LOW) [N_OUT]
//   idx   - registered active index [SEL_W]
//   step  - one-cycle strobe on each scan advance
//   err   - direct-mode sel >= N_OUT
module decoder_scan #(
  parameter int SEL_W          = 3,
  parameter int N_OUT          = 8,
  parameter int DIV            = 4,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             step,
  output logic             err
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [N_OUT-1:0] IDLE =
    {N_OUT{OUT_ACTIVE_LOW}};
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(N_OUT - 1);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [SEL_W:0] LIM  = (SEL_W + 1)'(N_OUT);

  // XOR with the idle level turns one-hot into one-cold
  function automatic logic [N_OUT-1:0] onehot(
    input logic [SEL_W-1:0] k
  );
    onehot = (N_OUT'(1) << k) ^ IDLE;
  endfunction

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic [N_OUT-1:0] y_d;
  logic [SEL_W-1:0] idx_d;
  logic             step_d;
  logic             err_d;
  logic             in_rng;
  logic             wrap;
  logic [SEL_W-1:0] nxt;

  assign in_rng = {1'b0, sel} < LIM;
  assign wrap   = cnt == CMAX;
  // wrap at N_OUT-1 so idx never reaches an unused code
  assign nxt    = (idx == LAST) ? '0
                                : idx + SEL_W'(1);

  always_comb begin
    cnt_d  = cnt;
    idx_d  = idx;
    y_d    = IDLE;
    step_d = 1'b0;
    err_d  = 1'b0;
    unique case (1'b1)
      !mode && en && in_rng: begin
        cnt_d = '0;
        y_d   = onehot(sel);
        idx_d = sel;
      end
      !mode && en && !in_rng: begin
        cnt_d = '0;
        err_d = 1'b1;
      end
      !mode && !en: begin
        cnt_d = '0;
      end
      mode && en && wrap: begin
        cnt_d  = '0;
        idx_d  = nxt;
        y_d    = onehot(nxt);
        step_d = 1'b1;
      end
      mode && en && !wrap: begin
        cnt_d = cnt + CW'(1);
        y_d   = onehot(idx);
      end
      mode && !en: begin
        cnt_d = cnt;
      end
      default: begin
        cnt_d = cnt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      y    <= IDLE;
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      idx  <= idx_d;
      y    <= y_d;
      step <= step_d;
      err  <= err_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: three decoder_scan configurations against
// a phase-based reference model plus directed literal checks.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;

  logic [7:0] y0;
  logic [5:0] y1;
  logic [3:0] y2;
  logic [2:0] i0, i1, i2;
  logic       s0, s1, s2;
  logic       e0, e1, e2;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .N_OUT(8), .DIV(4),
                 .OUT_ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .y(y0), .idx(i0), .step(s0), .err(e0));

  decoder_scan #(.SEL_W(3), .N_OUT(6), .DIV(3),
                 .OUT_ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .y(y1), .idx(i1), .step(s1), .err(e1));

  decoder_scan #(.SEL_W(3), .N_OUT(4), .DIV(1),
                 .OUT_ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .y(y2), .idx(i2), .step(s2), .err(e2));

  int NO[3] = '{8, 6, 4};
  int DV[3] = '{4, 3, 1};
  int AL[3] = '{0, 0, 1};

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // scan position as one integer: idx = ph/DIV, cnt = ph%DIV
  int         ph[3];
  logic [7:0] ey[3];
  int         eidx[3];
  bit         estep[3];
  bit         eerr[3];

  logic [7:0] ay[3];
  logic [2:0] aidx[3];
  logic       astep[3];
  logic       aerr[3];

  always_comb begin
    ay[0] = y0;
    ay[1] = {2'b00, y1};
    ay[2] = {4'h0, y2};
    aidx[0] = i0; aidx[1] = i1; aidx[2] = i2;
    astep[0] = s0; astep[1] = s1; astep[2] = s2;
    aerr[0] = e0; aerr[1] = e1; aerr[2] = e2;
  end

  function automatic logic [7:0] mask(int i);
    return 8'((1 << NO[i]) - 1);
  endfunction

  function automatic logic [7:0] idle(int i);
    return (AL[i] != 0) ? mask(i) : 8'h00;
  endfunction

  function automatic logic [7:0] dec(int i, int k);
    logic [7:0] v;
    v = 8'(1 << k);
    return (AL[i] != 0) ? (~v & mask(i)) : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        ph[i] = 0;
        ey[i] = idle(i);
        estep[i] = 1'b0;
        eerr[i] = 1'b0;
      end else if (!mode) begin
        ph[i] = (ph[i] / DV[i]) * DV[i];
        estep[i] = 1'b0;
        if (en && int'(sel) < NO[i]) begin
          ph[i] = int'(sel) * DV[i];
          ey[i] = dec(i, int'(sel));
          eerr[i] = 1'b0;
        end else begin
          ey[i] = idle(i);
          eerr[i] = en;
        end
      end else begin
        eerr[i] = 1'b0;
        if (!en) begin
          ey[i] = idle(i);
          estep[i] = 1'b0;
        end else begin
          ph[i] = (ph[i] + 1) % (NO[i] * DV[i]);
          ey[i] = dec(i, ph[i] / DV[i]);
          estep[i] = (ph[i] % DV[i]) == 0;
        end
      end
      eidx[i] = ph[i] / DV[i];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m_y%0d", i), 32'(ay[i]), 32'(ey[i]));
        chk($sformatf("m_idx%0d", i), 32'(aidx[i]),
            32'(eidx[i]));
        chk($sformatf("m_step%0d", i), 32'(astep[i]),
            32'(estep[i]));
        chk($sformatf("m_err%0d", i), 32'(aerr[i]),
            32'(eerr[i]));
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pat[4] = '{4'b1110, 4'b1101,
                         4'b1011, 4'b0111};

  initial begin
    int n;
    int base;
    int k;
    bit found;

    #12 rst_n = 1'b1;
    chk_on = 1'b1;

    // reset mid-scan, between edges
    mode = 1'b1;
    en = 1'b1;
    repeat (6) step_clk();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y0", 32'(y0), 32'h00);
    chk("rst_idx0", 32'(i0), 0);
    chk("rst_step0", 32'(s0), 0);
    chk("rst_err0", 32'(e0), 0);
    chk("rst_y2", 32'(y2), 32'hF);
    #2 rst_n = 1'b1;

    // direct decode
    mode = 1'b0;
    sel = 3'd5;
    step_clk();
    chk("dir_y0", 32'(y0), 32'h20);
    chk("dir_idx0", 32'(i0), 5);
    chk("dir_err0", 32'(e0), 0);
    en = 1'b0;
    step_clk();
    chk("dis_y0", 32'(y0), 32'h00);
    chk("dis_idx0", 32'(i0), 5);

    // out-of-range select on the 6-output decoder
    en = 1'b1;
    sel = 3'd7;
    step_clk();
    chk("oor_y1", 32'(y1), 32'h00);
    chk("oor_err1", 32'(e1), 1);
    chk("oor_idx1", 32'(i1), 5);
    sel = 3'd2;
    step_clk();
    chk("rng_y1", 32'(y1), 32'h04);
    chk("rng_err1", 32'(e1), 0);

    // scan wrap, N_OUT=6 DIV=3, from idx 0
    sel = 3'd0;
    step_clk();
    mode = 1'b1;
    for (int j = 1; j <= 36; j++) begin
      step_clk();
      k = (j / 3) % 6;
      chk("wrap_idx1", 32'(i1), 32'(k));
      chk("wrap_step1", 32'(s1), 32'((j % 3) == 0));
      chk("wrap_y1", 32'(y1), 32'(1 << k));
    end

    // freeze with cnt=1, then resume
    step_clk();
    en = 1'b0;
    repeat (5) begin
      step_clk();
      chk("frz_y1", 32'(y1), 0);
      chk("frz_step1", 32'(s1), 0);
      chk("frz_idx1", 32'(i1), 0);
    end
    en = 1'b1;
    n = 0;
    found = 1'b0;
    for (int j = 1; j <= 10 && !found; j++) begin
      step_clk();
      if (s1) begin
        found = 1'b1;
        n = j;
      end
    end
    chk("resume_lat1", 32'(n), 2);
    chk("resume_idx1", 32'(i1), 1);

    // DIV=1 active-low scan
    base = int'(i2);
    for (int j = 1; j <= 4; j++) begin
      step_clk();
      chk("d1_y2", 32'(y2), 32'(pat[(base + j) % 4]));
      chk("d1_step2", 32'(s2), 1);
    end
    mode = 1'b0;
    sel = 3'd2;
    step_clk();
    chk("d1_dir_y2", 32'(y2), 32'(4'b1011));
    chk("d1_dir_step2", 32'(s2), 0);

    // randomized traffic against the model
    for (int j = 0; j < 3000; j++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 40 == 0) mode = ~mode;
      sel = 3'($urandom);
      if ($urandom % 300 == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step_clk();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
